// File: rtl/button_debounce_pulse_pkg.sv
// Shared state encodings for switch/button conditioners.
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PRESS_CHK = 2'd1,
    S_HELD      = 2'd2,
    S_REL_CHK   = 2'd3
  } state_t;

endpackage

// File: rtl/button_debounce_pulse_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; resets to 0.
module button_debounce_pulse_sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: debounced level plus one-cycle press/release pulses.
// Define DEBOUNCE_REPEAT_EN to add auto-repeat press pulses while the button is held.
//
// state       | meaning
// S_IDLE      | button released and stable
// S_PRESS_CHK | sync high, counting stable cycles before accepting press
// S_HELD      | press accepted, btn_level high
// S_REL_CHK   | sync low, counting stable cycles before accepting release
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int RPT_W         = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  if (STABLE_CYCLES < 2 || CNT_W < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || RPT_W < 1)
  begin : g_param_err
    $error("button_debounce_pulse: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;
  logic             rpt_fire;

  button_debounce_pulse_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_first, rpt_first_nxt;

  // Repeat phase lives only while HELD with the button still down; any exit resets it.
  always_comb begin
    rpt_fire      = 1'b0;
    rpt_cnt_nxt   = '0;
    rpt_first_nxt = 1'b1;
    if (state == S_HELD && sync) begin
      if (rpt_cnt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
        rpt_fire      = 1'b1;
        rpt_first_nxt = 1'b0;
      end else begin
        rpt_cnt_nxt   = rpt_cnt + RPT_W'(1);
        rpt_first_nxt = rpt_first;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_first <= rpt_first_nxt;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

  // cnt defaults to 0 so it is cleared on every state entry and idles at 0.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sync) state_nxt = S_PRESS_CHK;
      end
      S_PRESS_CHK: begin
        if (!sync) begin
          state_nxt = S_IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HELD;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (!sync) state_nxt = S_REL_CHK;
        else if (rpt_fire) press_nxt = 1'b1;
      end
      S_REL_CHK: begin
        if (sync) begin
          state_nxt = S_HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = S_IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
